timer_clk_sel: RTL and testbench

Clock prescaler and source selector for the timer block. Divides the APB clock `pclk` by 2, 4, 8 and 16 from a single free-running counter and exposes all four divided clocks. Selects one of them as the timer count clock `clk_int` according to the 2-bit `cks` field of the timer control register. Also provides a one-`pclk`-cycle count-enable pulse, so the downstream counter can stay fully synchronous to `pclk`.

---
 rtl/timer_clk_sel.sv | 46 ++++
 tb/tb_timer_clk_sel.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_clk_sel.sv
// Timer clock prescaler: one free-running 4-bit counter supplies pclk/2../16.
// A registered select chooses the timer count clock and a one-cycle count enable.
module timer_clk_sel (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic [1:0] cks,
    output logic       clk2,
    output logic       clk4,
    output logic       clk8,
    output logic       clk16,
    output logic       clk_int,
    output logic       cnt_en
);

    logic [3:0] div_cnt;
    logic [1:0] cks_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            div_cnt <= '0;
            cks_q   <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
            cks_q   <= cks;
        end
    end

    // Divided clocks are plain counter bits, so they are glitch-free and phase-aligned.
    assign clk2  = div_cnt[0];
    assign clk4  = div_cnt[1];
    assign clk8  = div_cnt[2];
    assign clk16 = div_cnt[3];

    // Selection depends only on cks_q, so there is no path from cks to any output.
    always_comb begin
        clk_int = div_cnt[cks_q];
        cnt_en  = 1'b0;
        case (cks_q)
            2'b00:   cnt_en = div_cnt[0];
            2'b01:   cnt_en = &div_cnt[1:0];
            2'b10:   cnt_en = &div_cnt[2:0];
            default: cnt_en = &div_cnt[3:0];
        endcase
    end

endmodule

// File: tb/tb_timer_clk_sel.sv
// Self-checking bench for timer_clk_sel: vector table, hand sequences and a
// randomized run against an arithmetic model based on the pclk edge count.
module tb_timer_clk_sel;

    logic       pclk = 1'b0;
    logic       preset_n = 1'b1;
    logic [1:0] cks = 2'b00;
    logic       clk2, clk4, clk8, clk16, clk_int, cnt_en;

    int tests = 0;
    int fails = 0;

    // model state: edges since reset release and the select seen at the last edge
    int unsigned n   = 0;
    int unsigned ckq = 0;

    timer_clk_sel dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .cks     (cks),
        .clk2    (clk2),
        .clk4    (clk4),
        .clk8    (clk8),
        .clk16   (clk16),
        .clk_int (clk_int),
        .cnt_en  (cnt_en)
    );

    always #10 pclk = ~pclk;

    typedef struct {
        logic [1:0] cks;
        logic [5:0] exp;
    } vec_t;

    vec_t vec[16];

    function automatic logic [5:0] got();
        return {clk2, clk4, clk8, clk16, clk_int, cnt_en};
    endfunction

    // Expected {clk2,clk4,clk8,clk16,clk_int,cnt_en} after `cnt` edges with select `k`.
    function automatic logic [5:0] model(int unsigned cnt, int unsigned k);
        int unsigned p;
        logic [5:0]  r;
        p    = 2 << k;
        r[5] = (cnt % 2)  >= 1;
        r[4] = (cnt % 4)  >= 2;
        r[3] = (cnt % 8)  >= 4;
        r[2] = (cnt % 16) >= 8;
        r[1] = (cnt % p)  >= p / 2;
        r[0] = (cnt % p)  == p - 1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d, cks_q %0d)", name, act, exp, n, ckq);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        if (preset_n) begin
            n++;
            ckq = cks;
        end else begin
            n   = 0;
            ckq = 0;
        end
        #1;
    endtask

    task automatic do_reset(input int cyc);
        @(negedge pclk);
        preset_n = 1'b0;
        #1;
        check("reset_async", 32'(got()), 32'd0);
        for (int i = 0; i < cyc; i++) begin
            step();
            check("reset_hold", 32'(got()), 32'd0);
        end
        @(negedge pclk);
        preset_n = 1'b1;
        n   = 0;
        ckq = 0;
    endtask

    initial begin
        int unsigned prev_div, prev_en, rises, pulses, first_rise;
        int unsigned rise_cyc[2];
        int unsigned pulse_cyc[2];
        time         rise_t[2];
        logic [5:0]  g;

        // cks is the value present at the edge; exp is the output after it
        vec[0]  = '{2'b00, 6'b100011};
        vec[1]  = '{2'b00, 6'b010000};
        vec[2]  = '{2'b00, 6'b110011};
        vec[3]  = '{2'b01, 6'b001000};
        vec[4]  = '{2'b01, 6'b101000};
        vec[5]  = '{2'b01, 6'b011010};
        vec[6]  = '{2'b01, 6'b111011};
        vec[7]  = '{2'b11, 6'b000110};
        vec[8]  = '{2'b10, 6'b100100};
        vec[9]  = '{2'b10, 6'b010100};
        vec[10] = '{2'b11, 6'b110110};
        vec[11] = '{2'b11, 6'b001110};
        vec[12] = '{2'b11, 6'b101110};
        vec[13] = '{2'b11, 6'b011110};
        vec[14] = '{2'b11, 6'b111111};
        vec[15] = '{2'b00, 6'b000000};

        do_reset(10);
        for (int i = 0; i < 16; i++) begin
            cks = vec[i].cks;
            step();
            check("vector", 32'(got()), 32'(vec[i].exp));
        end

        // per-select periods, first rise edge and cnt_en spacing
        for (int k = 0; k < 4; k++) begin
            do_reset(2);
            cks = 2'(k);
            prev_div = 0; prev_en = 0; rises = 0; pulses = 0; first_rise = 0;
            for (int c = 1; c <= 40; c++) begin
                step();
                g = got();
                check("steady_model", 32'(g), 32'(model(n, ckq)));
                if (g[5-k] && prev_div == 0 && rises < 2) begin
                    rise_t[rises]   = $time;
                    rise_cyc[rises] = c;
                    rises++;
                end
                if (g[0] && prev_en == 0 && pulses < 2) begin
                    pulse_cyc[pulses] = c;
                    pulses++;
                end
                prev_div = g[5-k];
                prev_en  = g[0];
            end
            check("two_rises_seen", rises, 2);
            check("two_pulses_seen", pulses, 2);
            if (rises == 2) begin
                check("first_rise_edge", rise_cyc[0], 32'(1 << k));
                check("div_period_ns", 32'(rise_t[1] - rise_t[0]), 32'(40 << k));
            end
            if (pulses == 2)
                check("cnt_en_spacing", pulse_cyc[1] - pulse_cyc[0], 32'(2 << k));
        end

        // random select changes on arbitrary cycles
        do_reset(2);
        prev_en = 0;
        for (int i = 0; i < 20; i++) begin
            cks = 2'($urandom);
            repeat ($urandom_range(1, 15)) begin
                step();
                check("random_model", 32'(got()), 32'(model(n, ckq)));
                check("en_double", 32'(cnt_en && prev_en != 0 && ckq != 0), 32'd0);
                prev_en = cnt_en;
            end
        end

        // asynchronous reset in the middle of a count
        do_reset(2);
        cks = 2'b11;
        repeat (11) step();
        check("pre_midreset", 32'(got()), 32'(model(n, ckq)));
        #4;
        preset_n = 1'b0;
        #1;
        check("midreset_async", 32'(got()), 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        n   = 0;
        ckq = 0;
        step();
        check("restart_edge1", 32'(got()), 32'(model(n, ckq)));
        check("restart_clk2", 32'(clk2), 32'd1);

        // wrap: 64 edges with /16 gives four pulses, each at count 15
        do_reset(2);
        cks = 2'b11;
        pulses = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            check("wrap_model", 32'(got()), 32'(model(n, ckq)));
            if (cnt_en) begin
                pulses++;
                check("wrap_en_at_15", n % 16, 32'd15);
            end
        end
        check("wrap_pulses", pulses, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
